uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 105 ++++++++++
 tb/tb_uart_tx_arb.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - shares one UART transmitter between an rx echo FIFO and a message source
// Optional feature: define ECHO_CRLF_EN to send an LF after every echoed CR.
module uart_tx_arb #(
  parameter int ECHO_DEPTH = 4
) (
  input  logic       clk_uart,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] msg_data,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic       tx_busy,
  output logic [7:0] txdata,
  output logic       dataok,
  output logic       echo_ovf
);
  localparam int AW = $clog2(ECHO_DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;

  logic [7:0]    mem [ECHO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          last_msg;  // 1: message source holds the most recent grant
  logic          echo_req, fifo_full, push_ok, pop, grant, win_msg, crlf_go;

  assign echo_req  = (count != '0);
  assign fifo_full = (count == (AW+1)'(ECHO_DEPTH));

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    win_msg  = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (crlf_go) begin
          grant = 1'b1;
        end else if (echo_req || msg_valid) begin
          grant   = 1'b1;
          win_msg = msg_valid && (!echo_req || !last_msg);
          pop     = !win_msg;
        end
        if (grant) state_nx = LAUNCH;
      end
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_nx = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push_ok   = rx_valid && (!fifo_full || pop);
  assign msg_ready = win_msg && !reset;
  assign dataok    = (state == LAUNCH);

  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      txdata   <= 8'h00;
      last_msg <= 1'b1;
      echo_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      if (rx_valid && !push_ok) echo_ovf <= 1'b1;
      if (grant) begin
        txdata <= crlf_go ? 8'h0A : (win_msg ? msg_data : mem[rd_ptr]);
        if (!crlf_go) last_msg <= win_msg;
      end
    end
  end

  always_ff @(posedge clk_uart) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

`ifdef ECHO_CRLF_EN
  logic crlf_pend;

  // Armed when an echoed CR finishes; the LF then pre-empts arbitration.
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      crlf_pend <= 1'b0;
    end else if (state == WAIT_DONE && !tx_busy && !last_msg && txdata == 8'h0D) begin
      crlf_pend <= 1'b1;
    end else if (crlf_go) begin
      crlf_pend <= 1'b0;
    end
  end

  assign crlf_go = (state == IDLE) && crlf_pend;
`else
  assign crlf_go = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb with a transaction-level reference model
module tb_uart_tx_arb;
  localparam int DEPTH = 4;

  logic       clk_uart = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] msg_data;
  logic       msg_valid;
  logic       msg_ready;
  logic       tx_busy;
  logic [7:0] txdata;
  logic       dataok;
  logic       echo_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  logic msg_ack_q = 1'b0;

  uart_tx_arb #(.ECHO_DEPTH(DEPTH)) dut (
    .clk_uart (clk_uart),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .msg_data (msg_data),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .tx_busy  (tx_busy),
    .txdata   (txdata),
    .dataok   (dataok),
    .echo_ovf (echo_ovf)
  );

  always #5 clk_uart = ~clk_uart;

  // Message source: drops msg_valid in the cycle after an accepted handshake.
  always @(negedge clk_uart) msg_ack_q <= msg_valid && msg_ready;

  task automatic tick;
    @(posedge clk_uart);
    #1;
    if (msg_ack_q) msg_valid = 1'b0;
  endtask

  task automatic apply_reset;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    msg_valid = 1'b0; msg_data = 8'h00; tx_busy = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    tick;
  endtask

  // Acts as the transmitter for one frame already launched (called in the dataok cycle).
  task automatic release_tx;
    tick; tx_busy = 1'b1;
    tick; tx_busy = 1'b0;
    tick;
  endtask

  task automatic serve(output logic got, output logic [7:0] b);
    got = 1'b0;
    b = 8'h00;
    tx_busy = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick;
      @(negedge clk_uart);
      if (dataok === 1'b1) begin
        got = 1'b1;
        b = txdata;
      end
    end
    release_tx;
  endtask

  task automatic test_reset;
    logic bad;
    reset = 1'b1; msg_valid = 1'b1; msg_data = 8'h55; rx_valid = 1'b1; rx_data = 8'h21;
    tick; tick;
    @(negedge clk_uart);
    n_chk++;
    if ({dataok, msg_ready, echo_ovf} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 000", {dataok, msg_ready, echo_ovf});
    end
    n_chk++;
    if (txdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_txdata: got %h expected 00", txdata);
    end
    tick;
    reset = 1'b0; msg_valid = 1'b0; rx_valid = 1'b0;
    bad = 1'b0;
    repeat (5) begin tick; @(negedge clk_uart); if (dataok !== 1'b0) bad = 1'b1; end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL reset_fifo_empty: got dataok after reset expected none");
    end
  endtask

  task automatic test_single_echo;
    logic bad;
    apply_reset;
    rx_valid = 1'b1; rx_data = 8'h41;
    tick; rx_valid = 1'b0;
    @(negedge clk_uart);
    n_chk++;
    if (dataok !== 1'b0) begin
      n_fail++; $display("FAIL echo_n1: got dataok %b expected 0", dataok);
    end
    tick;
    @(negedge clk_uart);
    n_chk++;
    if (dataok !== 1'b1 || txdata !== 8'h41) begin
      n_fail++; $display("FAIL echo_n2: got %b/%h expected 1/41", dataok, txdata);
    end
    tick; tx_busy = 1'b1; msg_valid = 1'b1; msg_data = 8'h5A;
    bad = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_uart);
      if (dataok !== 1'b0 || msg_ready !== 1'b0) bad = 1'b1;
      tick;
    end
    tx_busy = 1'b0;
    @(negedge clk_uart);
    if (msg_ready !== 1'b0) bad = 1'b1;
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL echo_busy_window: got activity expected none before idle");
    end
    tick;
    @(negedge clk_uart);
    n_chk++;
    if (msg_ready !== 1'b1) begin
      n_fail++; $display("FAIL echo_idle_n14: got msg_ready %b expected 1", msg_ready);
    end
    tick;
    @(negedge clk_uart);
    n_chk++;
    if (dataok !== 1'b1 || txdata !== 8'h5A) begin
      n_fail++; $display("FAIL echo_then_msg: got %b/%h expected 1/5a", dataok, txdata);
    end
    release_tx;
  endtask

  task automatic test_contention;
    apply_reset;
    rx_valid = 1'b1; rx_data = 8'h31;
    tick; rx_valid = 1'b0; msg_valid = 1'b1; msg_data = 8'h48;
    @(negedge clk_uart);
    n_chk++;
    if (msg_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie_echo_first: got msg_ready %b expected 0", msg_ready);
    end
    tick;
    @(negedge clk_uart);
    n_chk++;
    if (dataok !== 1'b1 || txdata !== 8'h31) begin
      n_fail++; $display("FAIL tie_echo_byte: got %b/%h expected 1/31", dataok, txdata);
    end
    tick; tx_busy = 1'b1;
    tick; tx_busy = 1'b0;
    @(negedge clk_uart);
    n_chk++;
    if (msg_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie_ready_early: got %b expected 0", msg_ready);
    end
    tick;
    @(negedge clk_uart);
    n_chk++;
    if (msg_ready !== 1'b1) begin
      n_fail++; $display("FAIL tie_ready_grant: got %b expected 1", msg_ready);
    end
    tick;
    @(negedge clk_uart);
    n_chk++;
    if (dataok !== 1'b1 || txdata !== 8'h48 || msg_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie_msg_byte: got %b/%h/%b expected 1/48/0", dataok, txdata, msg_ready);
    end
    release_tx;
  endtask

  task automatic test_overflow;
    logic [7:0] b[6];
    logic [7:0] v;
    logic got, bad;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom_range(1, 255));
    apply_reset;
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = b[i];
      @(negedge clk_uart);
      if (i == 2) begin
        n_chk++;
        if (dataok !== 1'b1 || txdata !== b[0]) begin
          n_fail++; $display("FAIL ovf_first_launch: got %b/%h expected 1/%h", dataok, txdata, b[0]);
        end
      end
      if (i == 5) begin
        n_chk++;
        if (echo_ovf !== 1'b0) begin
          n_fail++; $display("FAIL ovf_early: got %b expected 0", echo_ovf);
        end
      end
      tick;
    end
    rx_valid = 1'b0;
    @(negedge clk_uart);
    n_chk++;
    if (echo_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b expected 1", echo_ovf);
    end
    for (int i = 1; i < 5; i++) begin
      serve(got, v);
      n_chk++;
      if (!got || v !== b[i]) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got %b/%h expected 1/%h", i, got, v, b[i]);
      end
    end
    bad = 1'b0;
    repeat (8) begin tick; @(negedge clk_uart); if (dataok !== 1'b0) bad = 1'b1; end
    n_chk++;
    if (bad || echo_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_dropped_sticky: got extra=%b ovf=%b expected 0/1", bad, echo_ovf);
    end
  endtask

  task automatic test_full_pop;
    logic [7:0] b[6];
    logic [7:0] v;
    logic got;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom_range(1, 255));
    apply_reset;
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = b[i];
      tick;
    end
    rx_valid = 1'b0; tx_busy = 1'b0;
    tick;
    rx_valid = 1'b1; rx_data = b[5];
    tick;
    rx_valid = 1'b0;
    @(negedge clk_uart);
    n_chk++;
    if (dataok !== 1'b1 || txdata !== b[1] || echo_ovf !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_grant: got %b/%h/%b expected 1/%h/0", dataok, txdata, echo_ovf, b[1]);
    end
    release_tx;
    for (int i = 2; i < 6; i++) begin
      serve(got, v);
      n_chk++;
      if (!got || v !== b[i]) begin
        n_fail++; $display("FAIL full_pop_order[%0d]: got %b/%h expected 1/%h", i, got, v, b[i]);
      end
    end
    n_chk++;
    if (echo_ovf !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_ovf: got %b expected 0", echo_ovf);
    end
  endtask

  task automatic test_crlf;
    logic [7:0] exp_seq[$];
    logic [7:0] v;
    logic got, bad;
    exp_seq = '{8'h0D};
`ifdef ECHO_CRLF_EN
    exp_seq.push_back(8'h0A);
`endif
    exp_seq.push_back(8'h48);
    apply_reset;
    rx_valid = 1'b1; rx_data = 8'h0D;
    tick; rx_valid = 1'b0; msg_valid = 1'b1; msg_data = 8'h48;
    foreach (exp_seq[i]) begin
      serve(got, v);
      n_chk++;
      if (!got || v !== exp_seq[i]) begin
        n_fail++; $display("FAIL crlf_order[%0d]: got %b/%h expected 1/%h", i, got, v, exp_seq[i]);
      end
    end
    bad = 1'b0;
    repeat (8) begin tick; @(negedge clk_uart); if (dataok !== 1'b0) bad = 1'b1; end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL crlf_extra: got extra dataok expected none");
    end
  endtask

  task automatic test_reset_mid;
    logic bad;
    apply_reset;
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom_range(1, 255));
      tick;
    end
    rx_valid = 1'b0; msg_valid = 1'b1; msg_data = 8'h77;
    @(negedge clk_uart);
    n_chk++;
    if (echo_ovf !== 1'b1 || txdata === 8'h00) begin
      n_fail++; $display("FAIL mid_setup: got ovf=%b txdata=%h expected 1/nonzero", echo_ovf, txdata);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({dataok, msg_ready, echo_ovf} !== 3'b000 || txdata !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_async: got %b/%h expected 000/00", {dataok, msg_ready, echo_ovf}, txdata);
    end
    tick; tick;
    msg_valid = 1'b0; tx_busy = 1'b0; reset = 1'b0;
    bad = 1'b0;
    repeat (6) begin tick; @(negedge clk_uart); if (dataok !== 1'b0) bad = 1'b1; end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL mid_no_dataok: got dataok after reset expected none");
    end
    rx_valid = 1'b1; rx_data = 8'hC3;
    tick; rx_valid = 1'b0;
    tick;
    @(negedge clk_uart);
    n_chk++;
    if (dataok !== 1'b1 || txdata !== 8'hC3) begin
      n_fail++; $display("FAIL mid_fresh_grant: got %b/%h expected 1/c3", dataok, txdata);
    end
    release_tx;
    bad = 1'b0;
    repeat (8) begin tick; @(negedge clk_uart); if (dataok !== 1'b0) bad = 1'b1; end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL mid_fifo_flushed: got stale byte expected none");
    end
  endtask

  // Reference: queue of echo bytes, one pending message, frame timing from the transmitter schedule.
  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] mq = 8'h00, gb, exp_tx = 8'h00;
    logic mv = 1'b0, last_msg = 1'b1, ovf = 1'b0, crlf_pend = 1'b0;
    logic grant, win_msg, is_crlf, pop;
    int free_at = 0, launch_at = -1, busy_from = -1, busy_to = -1;
    apply_reset;
    for (int c = 0; c < 3000; c++) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
      if (!mv && $urandom_range(0, 3) == 0) begin
        mv = 1'b1; mq = 8'($urandom);
      end
      msg_valid = mv; msg_data = mq;
      tx_busy = (c >= busy_from) && (c < busy_to);
      @(negedge clk_uart);
      grant = 1'b0; win_msg = 1'b0; is_crlf = 1'b0; gb = 8'h00;
      if (c >= free_at) begin
        if (crlf_pend) begin
          grant = 1'b1; is_crlf = 1'b1; gb = 8'h0A;
        end else if (q.size() != 0 || mv) begin
          grant   = 1'b1;
          win_msg = mv && (q.size() == 0 || !last_msg);
          gb      = win_msg ? mq : q[0];
        end
      end
      n_chk++;
      if (msg_ready !== (grant && win_msg)) begin
        n_fail++; $display("FAIL rand_msg_ready c=%0d: got %b expected %b", c, msg_ready, grant && win_msg);
      end
      n_chk++;
      if (dataok !== (c == launch_at)) begin
        n_fail++; $display("FAIL rand_dataok c=%0d: got %b expected %b", c, dataok, c == launch_at);
      end
      if (c == launch_at) begin
        n_chk++;
        if (txdata !== exp_tx) begin
          n_fail++; $display("FAIL rand_txdata c=%0d: got %h expected %h", c, txdata, exp_tx);
        end
      end
      n_chk++;
      if (echo_ovf !== ovf) begin
        n_fail++; $display("FAIL rand_ovf c=%0d: got %b expected %b", c, echo_ovf, ovf);
      end
      pop = grant && !win_msg && !is_crlf;
      if (rx_valid) begin
        if (q.size() == DEPTH && !pop) ovf = 1'b1;
        else q.push_back(rx_data);
      end
      if (pop) void'(q.pop_front());
      if (grant) begin
        launch_at = c + 1;
        exp_tx    = gb;
        busy_from = c + 2 + $urandom_range(0, 2);
        busy_to   = busy_from + $urandom_range(1, 5);
        free_at   = busy_to + 1;
        if (!is_crlf) last_msg = win_msg;
        if (win_msg) mv = 1'b0;
        crlf_pend = 1'b0;
`ifdef ECHO_CRLF_EN
        if (!win_msg && !is_crlf && gb == 8'h0D) crlf_pend = 1'b1;
`endif
      end
      @(posedge clk_uart);
      #1;
    end
    rx_valid = 1'b0; msg_valid = 1'b0; tx_busy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    msg_valid = 1'b0; msg_data = 8'h00; tx_busy = 1'b0;
    test_reset;
    test_single_echo;
    test_contention;
    test_overflow;
    test_full_pop;
    test_crlf;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
